// File: rtl/rv32_pkg.sv
// rv32_pkg: constants and types shared by the RV32 fetch-path blocks.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_BOOT  = 2'd0,
    PC_FETCH = 2'd1,
    PC_HOLD  = 2'd2
  } pc_ctrl_state_t;

  // Redirect ranking; a larger value wins.
  typedef logic [1:0] redir_prio_t;
  localparam redir_prio_t PRIO_NONE   = 2'd0;
  localparam redir_prio_t PRIO_BRANCH = 2'd1;
  localparam redir_prio_t PRIO_JUMP   = 2'd2;
  localparam redir_prio_t PRIO_TRAP   = 2'd3;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: instruction-memory request/ready handshake.
interface pc_ctrl_if;
  import rv32_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;

  modport master (output imem_req, output imem_addr, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_ready);

endinterface

// File: rtl/pc_ctrl_pc_next_sel.sv
// pc_next_sel: redirect priority mux (trap > jump > branch) plus the
// sequential successor and the target alignment check.
// Build option: PC_CTRL_MISALIGN_TRAP_EN turns a misaligned jump/branch
// target into a trap redirect; otherwise the low target bits are cleared.
module pc_next_sel
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] pc_current,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            redirect,
  output logic [XLEN-1:0] redir_addr,
  output redir_prio_t     redir_prio,
  output logic [XLEN-1:0] seq_addr,
  output logic            misalign
);

  logic [XLEN-1:0] ctl_tgt;
  redir_prio_t     ctl_prio;

  assign seq_addr = pc_current + XLEN'(INSN_BYTES);

  // Pick the winning redirect; trap targets pass through unchecked.
  always_comb begin
    ctl_tgt    = jump ? jump_target : branch_target;
    ctl_prio   = jump ? PRIO_JUMP : PRIO_BRANCH;
    redirect   = trap | jump | branch_taken;
    redir_addr = trap_vector;
    redir_prio = PRIO_TRAP;
    misalign   = 1'b0;
    if (!trap) begin
      if (jump || branch_taken) begin
`ifdef PC_CTRL_MISALIGN_TRAP_EN
        if (is_aligned(ctl_tgt)) begin
          redir_addr = ctl_tgt;
          redir_prio = ctl_prio;
        end else begin
          // Misaligned control transfer becomes a trap, ranked as one.
          misalign = 1'b1;
        end
`else
        redir_addr = ctl_tgt & ~XLEN'(3);
        redir_prio = ctl_prio;
`endif
      end else begin
        redir_prio = PRIO_NONE;
      end
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch sequencer. Drives the next-PC value for the external pc
// register, issues instruction-memory requests and remembers redirects that
// arrive while no fetch is being accepted.
// Build option: PC_CTRL_MISALIGN_TRAP_EN (see pc_next_sel).
//
//   state | meaning
//   BOOT  | one cycle after reset, pc_next = RESET_VECTOR, no request
//   FETCH | request issued at pc_current (unless stalled with none pending)
//   HOLD  | stalled, no request until stall drops
module pc_ctrl
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_current,
  output logic [XLEN-1:0] pc_next,
  pc_ctrl_if.master       imem,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            misalign
);

  localparam logic [1:0] S_BOOT  = PC_BOOT;
  localparam logic [1:0] S_FETCH = PC_FETCH;
  localparam logic [1:0] S_HOLD  = PC_HOLD;

  logic [1:0]      state_q, state_d;
  logic            outstanding_q;
  logic            pend_valid_q;
  logic [XLEN-1:0] pend_addr_q;
  redir_prio_t     pend_prio_q;

  logic            redirect, mis_raw, xfer, take_redir;
  logic [XLEN-1:0] redir_addr, seq_addr;
  redir_prio_t     redir_prio;

  pc_next_sel u_sel (
    .pc_current    (pc_current),
    .trap          (trap),
    .trap_vector   (trap_vector),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .redirect      (redirect),
    .redir_addr    (redir_addr),
    .redir_prio    (redir_prio),
    .seq_addr      (seq_addr),
    .misalign      (mis_raw)
  );

  // A request already on the bus stays up until accepted, even under stall.
  assign imem.imem_req  = (state_q == S_FETCH) & (outstanding_q | ~stall);
  assign imem.imem_addr = pc_current;
  assign xfer           = imem.imem_req & imem.imem_ready;

  // A new redirect beats a remembered one of equal or lower rank.
  assign take_redir = redirect & (~pend_valid_q | (redir_prio >= pend_prio_q));

  // Next PC: hold the current PC unless a fetch is accepted.
  always_comb begin
    pc_next = pc_current;
    if (state_q == S_BOOT) begin
      pc_next = RESET_VECTOR;
    end else if (xfer) begin
      if (take_redir)        pc_next = redir_addr;
      else if (pend_valid_q) pc_next = pend_addr_q;
      else                   pc_next = seq_addr;
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (stall && !outstanding_q) state_d = S_HOLD;
      S_HOLD:  if (!stall) state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
  end

  // FSM state and outstanding-request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= imem.imem_req & ~imem.imem_ready;
    end
  end

  // Pending redirect: captured when no fetch is accepted, consumed by the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_prio_q  <= PRIO_NONE;
    end else if (xfer) begin
      pend_valid_q <= 1'b0;
    end else if (take_redir) begin
      pend_valid_q <= 1'b1;
      pend_addr_q  <= redir_addr;
      pend_prio_q  <= redir_prio;
    end
  end

  // Completed-fetch report and misalign pulse, one cycle after the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      misalign    <= 1'b0;
    end else begin
      fetch_valid <= xfer;
      if (xfer) fetch_pc <= pc_current;
      misalign    <= mis_raw;
    end
  end

endmodule
